// File: rtl/crazy_input.sv
// crazy_input
//   Arcade input front end. Merges PS/2 keyboard events and two joysticks
//   into the game's active-low input ports, stretches coin insertions over
//   a fixed number of video frames, and holds a DIP-switch byte that is
//   loaded from the download channel.
//
// Ports
//   CLK        system clock, all state on the rising edge
//   RESET      asynchronous, active-high reset
//   ps2_key    [10] event toggle, [9] pressed, [8:0] scan code (bit 8 = extended)
//   joy1/joy2  [0] R, [1] L, [2] D, [3] U, [4] Start1, [5] Start2, [6] Coin
//   I_VBLANK   vertical blank, synchronous to CLK
//   dn_wr      download write strobe
//   dn_index   download index (254 = DIP switches)
//   dn_addr    download address
//   dn_data    download data byte
//   O_IN0      active-low {P2 R,L,D,U, P1 R,L,D,U}
//   O_IN1      {0, coin, ~Start2, ~Start1, 4'b1111}
//   O_DIPSW1   DIP byte 0, not affected by RESET
//
// Coin stretcher
//   state    | meaning
//   IDLE     | waiting for a rising edge of the combined coin input
//   HOLD     | coin asserted, counting VBLANK rising edges down to zero
//   WAIT_REL | coin deasserted, waiting for the coin input to be released

module crazy_input #(
  parameter int COIN_FRAMES = 3
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [10:0] ps2_key,
  input  logic [15:0] joy1,
  input  logic [15:0] joy2,
  input  logic        I_VBLANK,
  input  logic        dn_wr,
  input  logic [7:0]  dn_index,
  input  logic [24:0] dn_addr,
  input  logic [7:0]  dn_data,
  output logic [7:0]  O_IN0,
  output logic [7:0]  O_IN1,
  output logic [7:0]  O_DIPSW1
);

  localparam int CW = (COIN_FRAMES < 1) ? 1 : $clog2(COIN_FRAMES + 1);

  // Key state register indices; several keys may feed one logical control.
  localparam logic [3:0] K_P1U  = 4'd0;
  localparam logic [3:0] K_P1D  = 4'd1;
  localparam logic [3:0] K_P1L  = 4'd2;
  localparam logic [3:0] K_P1R  = 4'd3;
  localparam logic [3:0] K_S1A  = 4'd4;
  localparam logic [3:0] K_S1B  = 4'd5;
  localparam logic [3:0] K_S2A  = 4'd6;
  localparam logic [3:0] K_S2B  = 4'd7;
  localparam logic [3:0] K_CNA  = 4'd8;
  localparam logic [3:0] K_CNB  = 4'd9;
  localparam logic [3:0] K_CNC  = 4'd10;
  localparam logic [3:0] K_P2U  = 4'd11;
  localparam logic [3:0] K_P2D  = 4'd12;
  localparam logic [3:0] K_P2L  = 4'd13;
  localparam logic [3:0] K_P2R  = 4'd14;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HOLD     = 2'd1,
    WAIT_REL = 2'd2
  } coin_state_t;

  // ---------------------------------------------------------------------
  // Keyboard event detection and decode
  // ---------------------------------------------------------------------
  logic        tog_prev;
  logic        armed;
  logic        key_ev;
  logic        key_hit;
  logic [3:0]  key_idx;
  logic [14:0] keys;

  // armed stays low for the first cycle after reset so a toggle bit that
  // was already set during reset is only sampled, never decoded.
  assign key_ev = armed && (ps2_key[10] != tog_prev);

  always_comb begin
    key_hit = 1'b0;
    key_idx = 4'd0;
    casez (ps2_key[8:0])
      9'b?0111_0101: begin key_hit = 1'b1; key_idx = K_P1U; end  // x75
      9'b?0111_0010: begin key_hit = 1'b1; key_idx = K_P1D; end  // x72
      9'b?0110_1011: begin key_hit = 1'b1; key_idx = K_P1L; end  // x6B
      9'b?0111_0100: begin key_hit = 1'b1; key_idx = K_P1R; end  // x74
      9'h005:        begin key_hit = 1'b1; key_idx = K_S1A; end
      9'h016:        begin key_hit = 1'b1; key_idx = K_S1B; end
      9'h006:        begin key_hit = 1'b1; key_idx = K_S2A; end
      9'h01E:        begin key_hit = 1'b1; key_idx = K_S2B; end
      9'h004:        begin key_hit = 1'b1; key_idx = K_CNA; end
      9'h02E:        begin key_hit = 1'b1; key_idx = K_CNB; end
      9'h036:        begin key_hit = 1'b1; key_idx = K_CNC; end
      9'h02D:        begin key_hit = 1'b1; key_idx = K_P2U; end
      9'h02B:        begin key_hit = 1'b1; key_idx = K_P2D; end
      9'h023:        begin key_hit = 1'b1; key_idx = K_P2L; end
      9'h034:        begin key_hit = 1'b1; key_idx = K_P2R; end
      default:       begin key_hit = 1'b0; key_idx = 4'd0;  end
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      tog_prev <= 1'b0;
      armed    <= 1'b0;
      keys     <= '0;
    end else begin
      tog_prev <= ps2_key[10];
      armed    <= 1'b1;
      if (key_ev && key_hit) begin
        keys[key_idx] <= ps2_key[9];
      end
    end
  end

  // ---------------------------------------------------------------------
  // Combined controls
  // ---------------------------------------------------------------------
  logic p1_u, p1_d, p1_l, p1_r;
  logic p2_u, p2_d, p2_l, p2_r;
  logic start1, start2, coin_raw;

  assign p1_u     = keys[K_P1U] | joy1[3];
  assign p1_d     = keys[K_P1D] | joy1[2];
  assign p1_l     = keys[K_P1L] | joy1[1];
  assign p1_r     = keys[K_P1R] | joy1[0];
  assign p2_u     = keys[K_P2U] | joy2[3];
  assign p2_d     = keys[K_P2D] | joy2[2];
  assign p2_l     = keys[K_P2L] | joy2[1];
  assign p2_r     = keys[K_P2R] | joy2[0];
  assign start1   = keys[K_S1A] | keys[K_S1B] | joy1[4];
  assign start2   = keys[K_S2A] | keys[K_S2B] | joy1[5];
  assign coin_raw = keys[K_CNA] | keys[K_CNB] | keys[K_CNC] | joy1[6];

  // Opposing directions cancel each other, per axis and per player.
  logic p1_u_eff, p1_d_eff, p1_l_eff, p1_r_eff;
  logic p2_u_eff, p2_d_eff, p2_l_eff, p2_r_eff;

  assign p1_u_eff = p1_u & ~p1_d;
  assign p1_d_eff = p1_d & ~p1_u;
  assign p1_l_eff = p1_l & ~p1_r;
  assign p1_r_eff = p1_r & ~p1_l;
  assign p2_u_eff = p2_u & ~p2_d;
  assign p2_d_eff = p2_d & ~p2_u;
  assign p2_l_eff = p2_l & ~p2_r;
  assign p2_r_eff = p2_r & ~p2_l;

  // Only the low joystick bits carry controls.
  logic unused_joy;
  assign unused_joy = ^{joy1[15:7], joy2[15:4]};

  // ---------------------------------------------------------------------
  // Coin stretcher
  // ---------------------------------------------------------------------
  coin_state_t     coin_state;
  coin_state_t     coin_state_next;
  logic [CW-1:0]   coin_cnt;
  logic            coin_prev;
  logic            vb_prev;
  logic            coin_rise;
  logic            vb_rise;
  logic            coin_active;

  assign coin_rise = coin_raw & ~coin_prev;
  assign vb_rise   = I_VBLANK & ~vb_prev;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      coin_state <= IDLE;
      coin_cnt   <= '0;
      coin_prev  <= 1'b0;
      vb_prev    <= 1'b0;
    end else begin
      coin_state <= coin_state_next;
      coin_prev  <= coin_raw;
      vb_prev    <= I_VBLANK;
      if (coin_state == IDLE && coin_rise) begin
        coin_cnt <= CW'(COIN_FRAMES);
      end else if (coin_state == HOLD && vb_rise && coin_cnt != '0) begin
        coin_cnt <= coin_cnt - CW'(1);
      end
    end
  end

  always_comb begin
    coin_state_next = coin_state;
    case (coin_state)
      IDLE: begin
        if (coin_rise) coin_state_next = HOLD;
      end
      HOLD: begin
        // Leave on the VBLANK edge that takes the counter to zero; a zero
        // frame count still gives a single-cycle assertion.
        if (coin_cnt == '0 || (vb_rise && coin_cnt == CW'(1))) begin
          coin_state_next = WAIT_REL;
        end
      end
      WAIT_REL: begin
        if (!coin_raw) coin_state_next = IDLE;
      end
      default: coin_state_next = IDLE;
    endcase
  end

  always_comb begin
    coin_active = 1'b0;
    if (coin_state == HOLD) coin_active = 1'b1;
  end

  // ---------------------------------------------------------------------
  // Registered outputs
  // ---------------------------------------------------------------------
  logic [7:0] in0_next;
  logic [7:0] in1_next;

  assign in0_next = ~{p2_r_eff, p2_l_eff, p2_d_eff, p2_u_eff,
                      p1_r_eff, p1_l_eff, p1_d_eff, p1_u_eff};
  assign in1_next = {1'b0, coin_active, ~start2, ~start1, 4'hF};

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      O_IN0 <= 8'hFF;
      O_IN1 <= 8'h3F;
    end else begin
      O_IN0 <= in0_next;
      O_IN1 <= in1_next;
    end
  end

  // ---------------------------------------------------------------------
  // DIP switches: survive game resets, power up as zero
  // ---------------------------------------------------------------------
  logic [7:0] dip_q = 8'h00;

  always_ff @(posedge CLK) begin
    if (dn_wr && dn_index == 8'd254 && dn_addr == 25'd0) begin
      dip_q <= dn_data;
    end
  end

  assign O_DIPSW1 = dip_q;

endmodule

// File: tb/tb_crazy_input.sv
module tb_crazy_input;

  logic        CLK;
  logic        RESET;
  logic [10:0] ps2_key;
  logic [15:0] joy1;
  logic [15:0] joy2;
  logic        I_VBLANK;
  logic        dn_wr;
  logic [7:0]  dn_index;
  logic [24:0] dn_addr;
  logic [7:0]  dn_data;
  logic [7:0]  O_IN0;
  logic [7:0]  O_IN1;
  logic [7:0]  O_DIPSW1;

  int errors = 0;
  int checks = 0;
  logic tog = 1'b0;

  crazy_input #(.COIN_FRAMES(3)) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .ps2_key  (ps2_key),
    .joy1     (joy1),
    .joy2     (joy2),
    .I_VBLANK (I_VBLANK),
    .dn_wr    (dn_wr),
    .dn_index (dn_index),
    .dn_addr  (dn_addr),
    .dn_data  (dn_data),
    .O_IN0    (O_IN0),
    .O_IN1    (O_IN1),
    .O_DIPSW1 (O_DIPSW1)
  );

  initial begin
    CLK = 1'b0;
    forever #50 CLK = ~CLK;
  end

  // Inputs are driven and outputs sampled on the falling edge.
  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic key_event(input logic pressed, input logic [8:0] code);
    tog = ~tog;
    ps2_key = {tog, pressed, code};
    tick(1);
  endtask

  task automatic vblank();
    I_VBLANK = 1'b1;
    tick(1);
    I_VBLANK = 1'b0;
    tick(2);
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    #1;
    checks++;
    if (O_DIPSW1 !== 8'h00) begin
      errors++; $display("FAIL dip_powerup: got %h want %h", O_DIPSW1, 8'h00);
    end
    tick(2);
    checks++;
    if (O_IN0 !== 8'hFF) begin
      errors++; $display("FAIL reset_in0: got %h want %h", O_IN0, 8'hFF);
    end
    checks++;
    if (O_IN1 !== 8'h3F) begin
      errors++; $display("FAIL reset_in1: got %h want %h", O_IN1, 8'h3F);
    end
    RESET = 1'b0;
    tick(3);
    checks++;
    if (O_IN0 !== 8'hFF || O_IN1 !== 8'h3F) begin
      errors++; $display("FAIL idle_after_reset: got %h/%h want ff/3f", O_IN0, O_IN1);
    end
  endtask

  task automatic test_key_p1();
    key_event(1'b1, 9'h175);
    checks++;
    if (O_IN0 !== 8'hFF) begin
      errors++; $display("FAIL key_latency_1cyc: got %h want %h", O_IN0, 8'hFF);
    end
    tick(1);
    checks++;
    if (O_IN0 !== 8'hFE) begin
      errors++; $display("FAIL key_p1u_press: got %h want %h", O_IN0, 8'hFE);
    end
    key_event(1'b0, 9'h175);
    tick(1);
    checks++;
    if (O_IN0 !== 8'hFF) begin
      errors++; $display("FAIL key_p1u_release: got %h want %h", O_IN0, 8'hFF);
    end
    key_event(1'b1, 9'h075);
    key_event(1'b1, 9'h06B);
    tick(1);
    checks++;
    if (O_IN0 !== 8'hFA) begin
      errors++; $display("FAIL key_p1u_p1l: got %h want %h", O_IN0, 8'hFA);
    end
    key_event(1'b0, 9'h075);
    key_event(1'b0, 9'h16B);
    tick(1);
    checks++;
    if (O_IN0 !== 8'hFF) begin
      errors++; $display("FAIL key_p1_all_released: got %h want %h", O_IN0, 8'hFF);
    end
  endtask

  task automatic test_opposing();
    joy1 = 16'h000C;
    tick(1);
    checks++;
    if (O_IN0 !== 8'hFF) begin
      errors++; $display("FAIL opp_p1_ud: got %h want %h", O_IN0, 8'hFF);
    end
    joy1 = 16'h0008;
    tick(1);
    checks++;
    if (O_IN0 !== 8'hFE) begin
      errors++; $display("FAIL opp_p1_u_only: got %h want %h", O_IN0, 8'hFE);
    end
    joy1 = 16'h000C;
    joy2 = 16'h0004;
    tick(1);
    checks++;
    if (O_IN0 !== 8'hDF) begin
      errors++; $display("FAIL opp_players_indep: got %h want %h", O_IN0, 8'hDF);
    end
    joy2 = 16'h0002;
    key_event(1'b1, 9'h034);
    tick(1);
    checks++;
    if (O_IN0 !== 8'hFF) begin
      errors++; $display("FAIL opp_p2_lr: got %h want %h", O_IN0, 8'hFF);
    end
    key_event(1'b0, 9'h034);
    tick(1);
    checks++;
    if (O_IN0 !== 8'hBF) begin
      errors++; $display("FAIL opp_p2_l_only: got %h want %h", O_IN0, 8'hBF);
    end
    joy1 = 16'h0000;
    joy2 = 16'h0000;
    tick(1);
    checks++;
    if (O_IN0 !== 8'hFF) begin
      errors++; $display("FAIL opp_cleared: got %h want %h", O_IN0, 8'hFF);
    end
  endtask

  task automatic test_back_to_back();
    tog = ~tog;
    ps2_key = {tog, 1'b1, 9'h02D};
    joy1 = 16'h0001;
    tick(1);
    checks++;
    if (O_IN0 !== 8'hF7) begin
      errors++; $display("FAIL b2b_joy_first: got %h want %h", O_IN0, 8'hF7);
    end
    tick(1);
    checks++;
    if (O_IN0 !== 8'hE7) begin
      errors++; $display("FAIL b2b_key_and_joy: got %h want %h", O_IN0, 8'hE7);
    end
    key_event(1'b0, 9'h02D);
    joy1 = 16'h0000;
    key_event(1'b1, 9'h016);
    tick(1);
    checks++;
    if (O_IN1 !== 8'h2F || O_IN0 !== 8'hFF) begin
      errors++; $display("FAIL b2b_start1_key: got %h/%h want ff/2f", O_IN0, O_IN1);
    end
    joy1 = 16'h0020;
    tick(1);
    checks++;
    if (O_IN1 !== 8'h0F) begin
      errors++; $display("FAIL b2b_start2_joy: got %h want %h", O_IN1, 8'h0F);
    end
    key_event(1'b0, 9'h016);
    joy1 = 16'h0000;
    tick(1);
    checks++;
    if (O_IN1 !== 8'h3F) begin
      errors++; $display("FAIL b2b_starts_released: got %h want %h", O_IN1, 8'h3F);
    end
  endtask

  task automatic test_ignored_codes();
    key_event(1'b1, 9'h01C);
    key_event(1'b1, 9'h105);
    key_event(1'b1, 9'h12D);
    tick(1);
    checks++;
    if (O_IN0 !== 8'hFF || O_IN1 !== 8'h3F) begin
      errors++; $display("FAIL ignored_codes: got %h/%h want ff/3f", O_IN0, O_IN1);
    end
  endtask

  task automatic test_coin_pulse();
    joy1 = 16'h0040;
    tick(1);
    joy1 = 16'h0000;
    tick(1);
    checks++;
    if (O_IN1 !== 8'h7F) begin
      errors++; $display("FAIL coin_pulse_start: got %h want %h", O_IN1, 8'h7F);
    end
    vblank();
    checks++;
    if (O_IN1 !== 8'h7F) begin
      errors++; $display("FAIL coin_after_vb1: got %h want %h", O_IN1, 8'h7F);
    end
    joy1 = 16'h0040;
    tick(1);
    joy1 = 16'h0000;
    tick(1);
    vblank();
    checks++;
    if (O_IN1 !== 8'h7F) begin
      errors++; $display("FAIL coin_after_vb2: got %h want %h", O_IN1, 8'h7F);
    end
    vblank();
    checks++;
    if (O_IN1 !== 8'h3F) begin
      errors++; $display("FAIL coin_after_vb3: got %h want %h", O_IN1, 8'h3F);
    end
    vblank();
    vblank();
    checks++;
    if (O_IN1 !== 8'h3F) begin
      errors++; $display("FAIL coin_no_extension: got %h want %h", O_IN1, 8'h3F);
    end
  endtask

  task automatic test_coin_held();
    int held_frames;
    held_frames = 0;
    joy1 = 16'h0040;
    tick(2);
    for (int f = 0; f < 10; f++) begin
      if (O_IN1[6] === 1'b1) held_frames++;
      vblank();
    end
    checks++;
    if (held_frames !== 3) begin
      errors++; $display("FAIL coin_held_frames: got %0d want %0d", held_frames, 3);
    end
    joy1 = 16'h0000;
    tick(2);
    joy1 = 16'h0040;
    tick(2);
    checks++;
    if (O_IN1 !== 8'h7F) begin
      errors++; $display("FAIL coin_second_insert: got %h want %h", O_IN1, 8'h7F);
    end
    joy1 = 16'h0000;
    vblank();
    vblank();
    vblank();
    checks++;
    if (O_IN1 !== 8'h3F) begin
      errors++; $display("FAIL coin_second_done: got %h want %h", O_IN1, 8'h3F);
    end
  endtask

  task automatic test_reset_in_hold();
    key_event(1'b1, 9'h02E);
    tick(2);
    checks++;
    if (O_IN1 !== 8'h7F) begin
      errors++; $display("FAIL coin_key_hold: got %h want %h", O_IN1, 8'h7F);
    end
    RESET = 1'b1;
    #1;
    checks++;
    if (O_IN1 !== 8'h3F) begin
      errors++; $display("FAIL reset_drops_coin: got %h want %h", O_IN1, 8'h3F);
    end
    tick(1);
    RESET = 1'b0;
    tick(3);
    checks++;
    if (O_IN1 !== 8'h3F) begin
      errors++; $display("FAIL coin_key_cleared: got %h want %h", O_IN1, 8'h3F);
    end
  endtask

  task automatic test_dip();
    dn_wr = 1'b1; dn_index = 8'd254; dn_addr = 25'd0; dn_data = 8'hA5;
    tick(1);
    dn_wr = 1'b0;
    checks++;
    if (O_DIPSW1 !== 8'hA5) begin
      errors++; $display("FAIL dip_write: got %h want %h", O_DIPSW1, 8'hA5);
    end
    RESET = 1'b1;
    tick(1);
    RESET = 1'b0;
    tick(1);
    checks++;
    if (O_DIPSW1 !== 8'hA5) begin
      errors++; $display("FAIL dip_survives_reset: got %h want %h", O_DIPSW1, 8'hA5);
    end
    dn_wr = 1'b1; dn_index = 8'd254; dn_addr = 25'd1; dn_data = 8'h3C;
    tick(1);
    dn_index = 8'd253; dn_addr = 25'd0;
    tick(1);
    dn_wr = 1'b0; dn_index = 8'd254; dn_addr = 25'd0; dn_data = 8'h5A;
    tick(1);
    checks++;
    if (O_DIPSW1 !== 8'hA5) begin
      errors++; $display("FAIL dip_other_writes: got %h want %h", O_DIPSW1, 8'hA5);
    end
  endtask

  task automatic test_reset_toggle_held();
    RESET = 1'b1;
    tog = 1'b1;
    ps2_key = {tog, 1'b1, 9'h175};
    tick(1);
    RESET = 1'b0;
    tick(3);
    checks++;
    if (O_IN0 !== 8'hFF || O_IN1 !== 8'h3F) begin
      errors++; $display("FAIL toggle_through_reset: got %h/%h want ff/3f", O_IN0, O_IN1);
    end
    key_event(1'b1, 9'h175);
    tick(1);
    checks++;
    if (O_IN0 !== 8'hFE) begin
      errors++; $display("FAIL key_after_arm: got %h want %h", O_IN0, 8'hFE);
    end
    key_event(1'b0, 9'h175);
    tick(1);
    checks++;
    if (O_IN0 !== 8'hFF) begin
      errors++; $display("FAIL key_after_arm_release: got %h want %h", O_IN0, 8'hFF);
    end
  endtask

  initial begin
    RESET    = 1'b1;
    ps2_key  = 11'h000;
    joy1     = 16'h0000;
    joy2     = 16'h0000;
    I_VBLANK = 1'b0;
    dn_wr    = 1'b0;
    dn_index = 8'd0;
    dn_addr  = 25'd0;
    dn_data  = 8'h00;

    test_reset();
    test_key_p1();
    test_opposing();
    test_back_to_back();
    test_ignored_codes();
    test_coin_pulse();
    test_coin_held();
    test_reset_in_hold();
    test_dip();
    test_reset_toggle_held();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/crazy_input.md
CRAZY_INPUT -- requirements
Module: crazy_input

Interface
REQ-001 Parameter COIN_FRAMES, default 3: minimum number of VBLANK rising edges for which the coin output stays asserted per insertion.
REQ-002 CLK  in  1  system clock, 9.987 MHz; all state is clocked on its rising edge.
REQ-003 RESET  in  1  asynchronous, active-high reset.
REQ-004 ps2_key  in  11  keyboard event word: [10] toggles once per event, [9] pressed, [8:0] scan code (bit 8 = extended).
REQ-005 joy1, joy2  in  16 each  joystick bits: [0] R, [1] L, [2] D, [3] U, [4] Start1, [5] Start2, [6] Coin.
REQ-006 I_VBLANK  in  1  video vertical blank, synchronous to CLK.
REQ-007 dn_wr  in  1  download write strobe.
REQ-008 dn_index  in  8  download index.
REQ-009 dn_addr  in  25  download address.
REQ-010 dn_data  in  8  download data byte.
REQ-011 O_IN0  out  8  active-low {P2 R,L,D,U, P1 R,L,D,U}.
REQ-012 O_IN1  out  8  {0, coin (active-high), ~Start2, ~Start1, 1,1,1,1}.
REQ-013 O_DIPSW1  out  8  DIP byte 0.

Function
REQ-014 A key event SHALL be decoded in the cycle where ps2_key[10] differs from its registered previous value; the key's state register SHALL be loaded with ps2_key[9].
REQ-015 Code map: 'hX75/'hX72/'hX6B/'hX74 (bit 8 don't-care) -> P1 U/D/L/R; 'h005,'h016 -> Start1; 'h006,'h01E -> Start2; 'h004,'h02E,'h036 -> coin; 'h02D/'h02B/'h023/'h034 -> P2 U/D/L/R; all other codes are ignored.
REQ-016 Each logical control SHALL be the OR of its key state(s) and its joystick bit (P1 from joy1, P2 dirs from joy2, starts/coin from joy1 only).
REQ-017 Opposing directions: when U and D of one player are both active, both SHALL be driven inactive; the same rule applies to L and R; players are independent.
REQ-018 Coin stretcher states: IDLE, HOLD, WAIT_REL.
- IDLE -> HOLD on rising edge of combined coin; counter loads COIN_FRAMES.
- HOLD: coin output = 1; counter decrements on each I_VBLANK rising edge; -> WAIT_REL when counter reaches 0.
- WAIT_REL: coin output = 0; -> IDLE once combined coin = 0.
- A coin edge during HOLD or WAIT_REL SHALL be ignored.
REQ-019 O_IN0 and O_IN1 SHALL be registered, with exactly one cycle of latency from the decoded/combined control state to the outputs.
REQ-020 A DIP write (dn_wr=1, dn_index=254, dn_addr=0) SHALL load dn_data into O_DIPSW1 on the same edge; writes to other addresses or indexes SHALL not affect it.
REQ-021 A key event and a joystick change in the same cycle SHALL both take effect, ORed.

Reset
REQ-022 RESET SHALL asynchronously clear all key states, set the coin FSM to IDLE with counter 0, clear the VBLANK edge register, drive O_IN0 = 8'hFF, and drive O_IN1 = 8'h3F.
REQ-023 After reset is released, the first cycle SHALL only sample ps2_key[10] into the previous-toggle register, with no decode, so no spurious event is processed.
REQ-024 The O_DIPSW1 register SHALL be exempt from RESET, holding its value across game resets; its power-up value is 8'h00.
REQ-025 If RESET asserts during HOLD, the coin output SHALL drop to 0 immediately.

Verification
REQ-026 Toggle ps2_key[10] with pressed=1, code 'h175 -> O_IN0 = 8'hFE after 2 cycles; repeat with pressed=0 -> 8'hFF.
REQ-027 joy1[3] and joy1[2] both held -> O_IN0[1:0] = 2'b11; then release joy1[2] -> O_IN0[0] = 0.
REQ-028 Coin pulse lasting 1 cycle, COIN_FRAMES=3 -> O_IN1[6] = 1 until the 3rd subsequent VBLANK rising edge, then 0; a second pulse while held produces no extension.
REQ-029 Coin held continuously for 10 frames -> exactly one 3-frame assertion; release then press -> a second assertion.
REQ-030 DIP write of 8'hA5 at index 254, addr 0, then pulse RESET -> O_DIPSW1 = 8'hA5; a write at addr 1 leaves it unchanged.
REQ-031 Hold ps2_key[10]=1 through RESET release -> no key state changes; O_IN0 = 8'hFF, O_IN1 = 8'h3F.
